// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state encoding and digit helpers for the BCD rounder
package bcd_pkg;

  // Rounding mode encodings; 2'd3 is decoded as half-up by the decision logic
  localparam logic [1:0] RND_TRUNC     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_CARRY = 2'd2,
    ST_FIN   = 2'd3
  } bcd_state_t;

  // A BCD digit is legal only in the range 0..9
  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Increment one BCD digit; returns {carry, digit}, 9 rolls over to 0 with carry
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    if (d >= 4'd9) begin
      return 5'b1_0000;
    end else begin
      return {1'b0, d + 4'd1};
    end
  endfunction

endpackage

// File: rtl/bcd_round_decide.sv
// rtl/bcd_round_decide.sv - combinational round-up decision and BCD validity check
module bcd_round_decide
  import bcd_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int POS_W  = $clog2(DIGITS)
) (
  input  logic [4*DIGITS-1:0] work,
  input  logic [POS_W-1:0]    pos,
  input  logic [1:0]          mode,
  output logic                up,
  output logic                bcd_err
);

  logic [3:0] first_disc;
  logic       sticky;
  logic       kept_odd;
  logic       err;

  // Extract first discarded digit, sticky bit below it, parity of kept LSD, and flag bad digits
  always_comb begin
    first_disc = 4'd0;
    sticky     = 1'b0;
    kept_odd   = 1'b0;
    err        = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(work[4*i +: 4])) err = 1'b1;
      if (i == int'(pos) - 1) first_disc = work[4*i +: 4];
      if ((i < int'(pos) - 1) && (work[4*i +: 4] != 4'd0)) sticky = 1'b1;
      if (i == int'(pos)) kept_odd = work[4*i];
    end
  end

  // Mode-dependent round-up; nothing discarded or a malformed input never rounds
  always_comb begin
    up = 1'b0;
    case (mode)
      RND_TRUNC:     up = 1'b0;
      RND_HALF_EVEN: up = (first_disc > 4'd5) ||
                          ((first_disc == 4'd5) && sticky) ||
                          ((first_disc == 4'd5) && !sticky && kept_odd);
      default:       up = (first_disc >= 4'd5);
    endcase
    if ((pos == '0) || err) up = 1'b0;
  end

  assign bcd_err = err;

endmodule

// File: rtl/bcd_round_seq.sv
// rtl/bcd_round_seq.sv - sequential BCD rounder, one carry digit per clock; BCD_ROUND_SAT_EN selects saturate-on-overflow
module bcd_round_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int POS_W  = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [POS_W-1:0]    round_pos,
  input  logic [1:0]          mode,
  output logic [4*DIGITS-1:0] digits_out,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                bcd_err
);

  localparam logic [POS_W-1:0] LAST = POS_W'(DIGITS - 1);

  bcd_state_t          state;
  logic [4*DIGITS-1:0] work;
  logic [POS_W-1:0]    pos_r;
  logic [1:0]          mode_r;
  logic [POS_W-1:0]    idx;
  logic                ovf_r;
  logic                err_r;

  logic [POS_W-1:0]    pos_clamped;
  logic [4*DIGITS-1:0] keep_mask;
  logic [3:0]          cur_digit;
  logic [4:0]          inc_res;
  logic                dec_up;
  logic                dec_err;

  assign pos_clamped = (round_pos > LAST) ? LAST : round_pos;
  assign cur_digit   = work[{idx, 2'b00} +: 4];
  assign inc_res     = bcd_digit_inc(cur_digit);

  // Nibble mask keeping digits at or above the rounding position
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(pos_r)) keep_mask[4*i +: 4] = 4'hF;
    end
  end

`ifdef BCD_ROUND_SAT_EN
  logic [4*DIGITS-1:0] sat_val;

  // Saturated result: 9 in every kept digit, discarded digits stay 0
  always_comb begin
    sat_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(pos_r)) sat_val[4*i +: 4] = 4'd9;
    end
  end
`endif

  bcd_round_decide #(
    .DIGITS (DIGITS),
    .POS_W  (POS_W)
  ) u_decide (
    .work    (work),
    .pos     (pos_r),
    .mode    (mode_r),
    .up      (dec_up),
    .bcd_err (dec_err)
  );

  // Control FSM and datapath: capture, evaluate, ripple carry one digit per cycle, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      work       <= '0;
      pos_r      <= '0;
      mode_r     <= RND_TRUNC;
      idx        <= '0;
      ovf_r      <= 1'b0;
      err_r      <= 1'b0;
      digits_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work   <= digits_in;
            pos_r  <= pos_clamped;
            mode_r <= mode;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          err_r <= dec_err;
          if (dec_err) begin
            // malformed input is passed through untouched
            state <= ST_FIN;
          end else begin
            work <= work & keep_mask;
            if (dec_up) begin
              idx   <= pos_r;
              state <= ST_CARRY;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_CARRY: begin
          if (inc_res[4]) begin
            work[{idx, 2'b00} +: 4] <= 4'd0;
            if (idx == LAST) begin
              ovf_r <= 1'b1;
`ifdef BCD_ROUND_SAT_EN
              work  <= sat_val;
`endif
              state <= ST_FIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            work[{idx, 2'b00} +: 4] <= inc_res[3:0];
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          digits_out <= work;
          overflow   <= ovf_r;
          bcd_err    <= err_r;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_round_seq.md
Name: bcd_round_seq

Overview:
- Parametrised, sequential successor to the fixed 6-digit BCD rounder in the frequency-counter display path.
- Rounds a DIGITS-wide packed BCD value at a run-time selectable digit position.
- Supports truncate, half-up and half-even modes.
- Propagates the carry one digit per clock, so timing closes for any DIGITS.
- Sits between the binary-to-BCD converter and the display/UART formatter, with a start/done handshake.

Parameters:
- DIGITS, 6, number of BCD digits (≥2).
- POS_W, $clog2(DIGITS), width of round_pos.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- digits_in  in  4*DIGITS  packed BCD; digit 0 = [3:0] (units).
- round_pos  in  POS_W  number of low digits discarded; sampled with start.
- mode  in  2  0 truncate, 1 half-up, 2 half-even, 3 treated as half-up; sampled with start.
- digits_out  out  4*DIGITS  rounded result; discarded digits are 0.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when digits_out/overflow/bcd_err are valid.
- overflow  out  1  carry out of top digit; valid with done, held until next done.
- bcd_err  out  1  any input digit >9; valid with done, held until next done.

Behaviour:
- Reset (async, rst=1): state IDLE; digits_out=0, busy=0, done=0, overflow=0, bcd_err=0; internal work register and index cleared. Reset mid-operation aborts with no done.
- States: IDLE, EVAL, CARRY, FIN.
- IDLE:
  - start=1 → capture digits_in, round_pos, mode; go to EVAL. busy goes high next cycle.
  - round_pos > DIGITS-1 is clamped to DIGITS-1.
- EVAL (1 cycle):
  - Definitions: f = digit[p-1] (first discarded digit); s = OR(digit[p-2:0] ≠ 0) (sticky); k = digit[p] (kept LSD).
  - up for mode 0 (truncate): up=0.
  - up for half-up: up = (f≥5).
  - up for half-even: up = (f>5) | (f==5 & s) | (f==5 & !s & k[0]).
  - p=0 → up=0; output equals input.
  - Digits below p are zeroed.
  - bcd_err computed over all input digits. If bcd_err=1, work := input unmodified and up is forced to 0.
  - up=0 → FIN. up=1 → idx:=p, go to CARRY.
- CARRY (one digit per cycle):
  - digit[idx]==9 → digit:=0. If idx==DIGITS-1, set overflow and go to FIN; otherwise idx++ and stay in CARRY.
  - digit[idx]<9 → digit+1, go to FIN.
- FIN: digits_out<=work, done<=1 (single cycle), busy<=0, go to IDLE.
- Latency: done is visible after edge 2+C, counted from the edge that accepted start. C = number of CARRY cycles, 0..DIGITS-p. Back-to-back requests are possible from the cycle done is high.
- start while busy is ignored; it is not queued.
- digits_out holds its value between operations.
- Overflow without the optional feature: all kept digits wrap to 0 and overflow=1.

Optional Feature:
- Macro BCD_ROUND_SAT_EN.
- Defined: on overflow, digits_out saturates to all 9s in kept positions, discarded digits remain 0, and overflow=1.
- Undefined: wrap-to-zero as above.
- No latency change in either case.

Decomposition:
- Package bcd_pkg holds:
  - mode constants RND_TRUNC/RND_HALF_UP/RND_HALF_EVEN;
  - state encoding;
  - function bcd_digit_valid;
  - function bcd_digit_inc, returning {carry, digit}.
- One natural sub-module, bcd_round_decide: combinational f/s/k extraction, up decision and bcd_err from work register, p and mode. The FSM/datapath stays in bcd_round_seq.

Test Plan (DIGITS=6):
- Half-up, p=1, 123456 → 123460; C=1; done after edge 3; overflow=0.
- Half-up, p=1, 099995 → 100000; C=5; busy high for 7 cycles; done after edge 7.
- Half-up, p=1, 999995 → 000000, overflow=1. With BCD_ROUND_SAT_EN: 999990, overflow=1.
- Half-even, p=2:
  - 123450 → 123400;
  - 123550 → 123600;
  - 123451 → 123500;
  - mode 3 with 123450 → 123500.
- Truncate, p=1, 123459 → 123450 (done after edge 2). Input with digit 0xA → output equals input, bcd_err=1, no rounding.
- Second start pulsed during CARRY is ignored (exactly one done). rst asserted mid-CARRY → all outputs 0, no done. Afterwards a fresh request completes correctly.
